// File: rtl/reaction_pkg.sv
// Shared widths, LED-pattern constants and error-FSM encoding for the reaction
// game statistics stage.
package reaction_pkg;
    localparam int TIME_W     = 4;
    localparam int CNT_W      = 8;
    localparam int HIST_DEPTH = 4;
    localparam int SEL_W      = 3;

    localparam logic [TIME_W-1:0] NO_BEST = 4'hF;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [SEL_W-1:0]  SEL_OFF = 3'b000;
    localparam logic [SEL_W-1:0]  SEL_ERR = 3'b111;

    typedef enum logic {
        ARMED  = 1'b0,
        IN_ERR = 1'b1
    } err_state_e;

    function automatic logic is_one_hot(input logic [SEL_W-1:0] sel);
        return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/reaction_scoreboard_if.sv
// Snoop bundle carrying the game's registered indicator and time-display outputs.
interface reaction_scoreboard_if;
    import reaction_pkg::*;

    logic [SEL_W-1:0]  led_select;
    logic [TIME_W-1:0] time_leds;

    modport master (output led_select, output time_leds);
    modport slave  (input  led_select, input  time_leds);
endinterface

// File: rtl/reaction_event_decode.sv
// Turns the game's LED pattern into single-cycle result and error-episode pulses.
//   state  | meaning
//   ARMED  | waiting for a fresh 111 flash to count an error episode
//   IN_ERR | episode in progress; needs HOLDOFF_CYCLES of 000 to re-arm
module reaction_event_decode
    import reaction_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] led_select,
    output logic             result_evt,
    output logic             error_evt
);
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

    logic [SEL_W-1:0] prev_sel_q, prev_sel_d;
    err_state_e       state_q, state_d;
    logic [HO_W-1:0]  holdoff_q, holdoff_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sel_q <= SEL_OFF;
            state_q    <= ARMED;
            holdoff_q  <= '0;
        end else begin
            prev_sel_q <= prev_sel_d;
            state_q    <= state_d;
            holdoff_q  <= holdoff_d;
        end
    end

    always_comb begin
        prev_sel_d = led_select;
        state_d    = state_q;
        holdoff_d  = holdoff_q;
        error_evt  = 1'b0;
        result_evt = is_one_hot(prev_sel_q) && (led_select == SEL_OFF);

        case (state_q)
            ARMED: begin
                holdoff_d = '0;
                if (led_select == SEL_ERR && prev_sel_q != SEL_ERR) begin
                    state_d   = IN_ERR;
                    error_evt = 1'b1;
                end
            end
            IN_ERR: begin
                // Any lit LED restarts the quiet window, so flashes inside one
                // episode never re-arm the counter.
                if (led_select != SEL_OFF) begin
                    holdoff_d = '0;
                end else if (holdoff_q == HO_LAST) begin
                    holdoff_d = '0;
                    state_d   = ARMED;
                end else begin
                    holdoff_d = holdoff_q + HO_W'(1);
                end
            end
            default: state_d = ARMED;
        endcase
    end
endmodule

// File: rtl/reaction_scoreboard.sv
// Reaction-time statistics: last, best and 4-deep rolling average, plus round
// and error-episode counters, all derived by snooping the game outputs.
module reaction_scoreboard
    import reaction_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int HOLDOFF_CYCLES = CLK_FREQ / 50
) (
    input  logic                  clk,
    input  logic                  reset,
    reaction_scoreboard_if.slave  game,
    input  logic                  clear_stats,
    output logic [TIME_W-1:0]     last_time,
    output logic [TIME_W-1:0]     best_time,
    output logic [TIME_W-1:0]     avg_time,
    output logic                  avg_valid,
    output logic [CNT_W-1:0]      round_cnt,
    output logic [CNT_W-1:0]      error_cnt,
    output logic                  new_best
);
    localparam int HC_W  = $clog2(HIST_DEPTH + 1);
    localparam int SUM_W = TIME_W + $clog2(HIST_DEPTH);

    logic result_evt, error_evt;

    reaction_event_decode #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_decode (
        .clk        (clk),
        .reset      (reset),
        .led_select (game.led_select),
        .result_evt (result_evt),
        .error_evt  (error_evt)
    );

    logic [TIME_W-1:0] last_q, last_d, best_q, best_d, avg_q, avg_d;
    logic [CNT_W-1:0]  round_q, round_d, error_q, error_d;
    logic [HC_W-1:0]   hist_count_q, hist_count_d;
    logic              new_best_q, new_best_d;
    logic [TIME_W-1:0] hist_q [HIST_DEPTH];
    logic [TIME_W-1:0] hist_d [HIST_DEPTH];
    logic [SUM_W-1:0]  sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q       <= '0;
            best_q       <= NO_BEST;
            avg_q        <= '0;
            round_q      <= '0;
            error_q      <= '0;
            hist_count_q <= '0;
            new_best_q   <= 1'b0;
            hist_q       <= '{default: '0};
        end else begin
            last_q       <= last_d;
            best_q       <= best_d;
            avg_q        <= avg_d;
            round_q      <= round_d;
            error_q      <= error_d;
            hist_count_q <= hist_count_d;
            new_best_q   <= new_best_d;
            hist_q       <= hist_d;
        end
    end

    always_comb begin
        last_d       = last_q;
        best_d       = best_q;
        round_d      = round_q;
        error_d      = error_q;
        hist_count_d = hist_count_q;
        new_best_d   = 1'b0;
        hist_d       = hist_q;
        sum          = '0;

        if (clear_stats) begin
            last_d       = '0;
            best_d       = NO_BEST;
            round_d      = '0;
            error_d      = '0;
            hist_count_d = '0;
            hist_d       = '{default: '0};
        end else begin
            if (result_evt) begin
                last_d = game.time_leds;
                for (int i = HIST_DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
                hist_d[0] = game.time_leds;
                round_d   = sat_inc(round_q);
                if (hist_count_q != HC_W'(HIST_DEPTH)) hist_count_d = hist_count_q + HC_W'(1);
                // Empty history means no best yet, so even a 15 counts as an improvement.
                if (hist_count_q == '0 || game.time_leds < best_q) begin
                    best_d     = game.time_leds;
                    new_best_d = 1'b1;
                end
            end
            if (error_evt) error_d = sat_inc(error_q);
        end

        for (int i = 0; i < HIST_DEPTH; i++) sum = sum + SUM_W'(hist_d[i]);
        avg_d = sum[SUM_W-1 -: TIME_W];
    end

    assign last_time = last_q;
    assign best_time = best_q;
    assign avg_time  = avg_q;
    assign avg_valid = (hist_count_q == HC_W'(HIST_DEPTH));
    assign round_cnt = round_q;
    assign error_cnt = error_q;
    assign new_best  = new_best_q;
endmodule

// File: doc/reaction_scoreboard.md
Name: reaction_scoreboard

Overview:
- Statistics stage directly downstream of the reaction game.
- Snoops the game's registered `led_select[2:0]` and `time_leds[3:0]` outputs on the same clock and decodes two events from them: round completed and early-press error.
- Maintains last, best and rolling-average reaction times plus round and error counts, for display or host readout.
- Needs no handshake back to the game.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- HOLDOFF_CYCLES, CLK_FREQ/50, cycles `led_select` must stay 3'b000 before a new error episode can be counted (20 ms, two game ticks).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- led_select  in  3  game indicator LEDs: one-hot during a round, 3'b111/000 flashing on error.
- time_leds  in  4  game reaction-time display.
- clear_stats  in  1  synchronous clear of all statistics.
- last_time  out  4  most recent reaction time.
- best_time  out  4  minimum reaction time; 4'hF when no result exists yet.
- avg_time  out  4  mean of the last four results, floor.
- avg_valid  out  1  high once at least four results have been captured.
- round_cnt  out  8  completed rounds, saturating at 255.
- error_cnt  out  8  error episodes, saturating at 255.
- new_best  out  1  one-cycle pulse when best_time improves.

Behaviour:
- Reset (async assert, sync release) sets:
  - last_time=0, best_time=4'hF, avg_time=0.
  - avg_valid=0, round_cnt=0, error_cnt=0, new_best=0.
  - History regs=0, hist_count=0.
  - prev_sel=0, error FSM in ARMED, holdoff counter=0.
- prev_sel registers led_select every cycle. Inputs are same-clock registered signals, so there is no synchroniser.
- Result event (combinational):
  - Condition: prev_sel is one-hot (001/010/100) and led_select==000.
  - time_leds is sampled in that same cycle.
  - Value 0 is a legal result; 15 means saturated (slow).
- Result handling, registered on the next edge (1-cycle latency):
  - last_time <= time_leds.
  - History shift: h3<=h2, h2<=h1, h1<=h0, h0<=time_leds.
  - round_cnt++ unless already 255.
  - hist_count increments, saturating at 4. avg_valid = (hist_count==4).
  - If time_leds < best_time (strict), or no result has been recorded yet: best_time <= time_leds and new_best=1 for exactly one cycle. A tie gives no pulse.
  - A first result equal to 15 sets best_time=15 and pulses new_best.
- avg_time = (h0+h1+h2+h3)>>2:
  - 6-bit sum, registered with the history, so it is consistent with last_time.
  - Value is meaningless while avg_valid=0; it is still driven from the zero-filled history.
- Error FSM states:
  - ARMED: when led_select==111 and prev_sel!=111, go to IN_ERR and error_cnt++ (saturating).
  - IN_ERR: led_select!=000 reloads the holdoff counter to 0. led_select==000 increments it. When the counter reaches HOLDOFF_CYCLES-1, go to ARMED.
  - Repeated 111 flashes within one episode are therefore counted once.
  - A result event cannot occur in IN_ERR, because 111 is not one-hot. If the decode fires anyway, the result is processed normally.
- clear_stats (synchronous):
  - Returns all statistics, history and hist_count to their reset values.
  - Does not reset prev_sel or the error FSM.
  - Takes priority over a result or error event in the same cycle; that event is dropped.
  - new_best stays 0.
- Counter widths:
  - round_cnt and error_cnt are 8 bits and hold at 255.
  - Holdoff counter is sized by $clog2(HOLDOFF_CYCLES+1).
- Reset mid-round or mid-error: everything returns to reset values immediately. The next 111 rising edge is counted as a new error.

Decomposition:
- Package reaction_pkg:
  - TIME_W=4, CNT_W=8, NO_BEST=4'hF, HIST_DEPTH=4.
  - LED-pattern constants: SEL_OFF=3'b000, SEL_ERR=3'b111.
  - Error FSM state encoding (ARMED, IN_ERR).
- Sub-module reaction_event_decode:
  - Contains prev_sel, the one-hot check, and the error FSM with its holdoff counter.
  - Outputs result_evt and error_evt pulses.
- The top level holds the statistics registers.

Test Plan (CLK_FREQ=1000, HOLDOFF_CYCLES=20):
- Reset, then hold led_select=000 -> best_time=F, round_cnt=0, avg_valid=0, all other outputs 0.
- led_select=010 for 5 cycles, then time_leds=7 and led_select=000 -> one cycle later last_time=7, best_time=7, new_best pulses once, round_cnt=1.
- Results 9, 3, 3, 5 after the 7 -> best_time=3; new_best pulses only on the first 3; after the fourth result avg_valid=1; after the fifth avg_time=(3+3+5+9)>>2=5; round_cnt=5.
- led_select toggling 111/000 every 10 cycles six times, then 000 for 25 cycles, then a fresh 111 -> error_cnt goes 0→1→2 (one increment per episode).
- clear_stats asserted in the same cycle as a result event with time 2 -> all stats reset, best_time=F, round_cnt=0, no new_best pulse.
- Async reset asserted between clock edges while IN_ERR with round_cnt=255 -> outputs go to reset values without waiting for a clock edge; round_cnt saturation previously verified by 260 results holding at 255.
